ds_dispatch: RTL and testbench
==============================

DS_DISPATCH -- requirements
Module: ds_dispatch

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 2, giving the dispatch group width in lanes.
REQ-002 SHALL have parameter NUM_RS, default 3, giving the number of target RS queues: 0=int, 1=intm, 2=mem.
REQ-003 SHALL have parameter CDB_WIDTH, default 3, giving the number of snooped CDB ports.
REQ-004 SHALL have parameter PRF_IDX, default 6, giving the physical register index width.
REQ-005 SHALL have parameter UOP_T, default uop_t, giving the uop type; it contains rs_type[1:0], rs1_phy, rs1_valid, rs2_phy and rs2_valid, and all other fields are opaque.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-009 SHALL have port rn_valid, input, ID_WIDTH bits: per-lane valid from rename.
REQ-010 SHALL have port rn_uop, input, ID_WIDTH x UOP_T: the group from rename.
REQ-011 SHALL have port rn_ready, output, 1 bit: the group is accepted this cycle when high together with any rn_valid.
REQ-012 SHALL have port ds_valid, output, NUM_RS x ID_WIDTH bits: lane w is pushed to RS t this cycle.
REQ-013 SHALL have port ds_uop, output, ID_WIDTH x UOP_T: the buffered group with snooped wakeups, broadcast to all RS.
REQ-014 SHALL have port rs_ready, input, NUM_RS bits: RS t has at least ID_WIDTH free slots.
REQ-015 SHALL have port cdb_valid, input, CDB_WIDTH bits: CDB broadcast valid.
REQ-016 SHALL have port cdb_rd_phy, input, CDB_WIDTH x PRF_IDX: CDB destination physical register.

Function
REQ-017 SHALL hold exactly one group in buf_uop[ID_WIDTH] plus a pending mask pend[ID_WIDTH]; the buffer is valid iff |pend.
REQ-018 SHALL assert ds_valid[t][w] = pend[w] && buf_uop[w].rs_type==t && rs_ready[t]; rs_type values >= NUM_RS SHALL never dispatch, and the lane stays pending (a verification assertion).
REQ-019 SHALL dispatch, for each RS t, all pending lanes of that type in one cycle or none; lanes of different types SHALL dispatch independently in the same or different cycles.
REQ-020 SHALL clear each pend[w] in the cycle after its ds_valid[*][w] is high.
REQ-021 SHALL drive rn_ready = ~flush && (pend & ~dispatching_now)==0, giving zero-bubble back-to-back groups.
REQ-022 SHALL, on accept (rn_ready && |rn_valid), load buf_uop <= rn_uop and pend <= rn_valid on the next edge; lanes with rn_valid=0 are never dispatched.
REQ-023 SHALL, on a buffered lane, set rs1_valid in buf_uop[w] when any cdb_valid[c] is high with cdb_rd_phy[c]==rs1_phy; rs2 SHALL be handled identically, and a set bit SHALL never clear while the lane is held.
REQ-024 SHALL drive ds_uop[w].rsX_valid = buf_uop[w].rsX_valid OR the same-cycle CDB match, so a wakeup coincident with the push is not lost.
REQ-025 SHALL NOT snoop incoming rn_uop on the load cycle; rename owns same-cycle wakeup of incoming uops.
REQ-026 SHALL, on flush, clear pend on the next edge, force rn_ready=0 and all ds_valid=0 in the flush cycle, and discard any rn_valid group.
REQ-027 SHALL produce ds_valid and ds_uop combinationally from registers, rs_ready and CDB; there is no path from rn_* to ds_*.
REQ-028 SHALL have latency of exactly 1 cycle from accept to the earliest ds_valid.

Reset
REQ-029 SHALL, on rst assertion, immediately (asynchronously) clear pend, forcing ds_valid=0 and rn_ready=1 while flush=0.
REQ-030 SHALL leave buf_uop contents unspecified after reset; they are never observed while pend=0.
REQ-031 SHALL treat reset mid-operation (partially dispatched group) as a full discard, with no further ds_valid for that group.

Verification
REQ-032 SHALL cover: group {int, mem} with rs_ready=3'b111 -> accepted cycle 0; ds_valid[0]=2'b01 and ds_valid[2]=2'b10 in cycle 1; rn_ready=1 in cycle 1.
REQ-033 SHALL cover: group {intm, int} with rs_ready[1]=0 for 3 cycles -> int lane pushed in cycle 1; intm lane pushed in cycle 4; rn_ready=0 in cycles 1-3.
REQ-034 SHALL cover: group {int, int} with rs_ready[0]=1 -> ds_valid[0]=2'b11 in a single cycle.
REQ-035 SHALL cover: buffered lane rs1_phy=12 stalled; cdb_valid[1]=1 with cdb_rd_phy[1]=12 in the stall cycle -> the pushed uop has rs1_valid=1; a match in the push cycle also -> rs1_valid=1.
REQ-036 SHALL cover: flush while a lane is pending -> no ds_valid after the flush cycle; the next group is accepted the cycle after flush.
REQ-037 SHALL cover: rst asserted mid-cycle with pend=2'b10 -> ds_valid=0 immediately, and rn_ready=1 after rst deassertion.

Source files
------------

// File: rtl/ds_dispatch_pkg.sv
// ds_dispatch_pkg: shared payload types for the dispatch stage.
// uop_t carries the fields dispatch needs:
//   rs_type             target reservation station (0=int, 1=intm, 2=mem)
//   rs1_phy / rs2_phy   physical source register indices
//   rs1_valid/rs2_valid source operand ready bits
// opcode and rd_phy are opaque to dispatch and are passed through untouched.
package ds_dispatch_pkg;

  localparam int unsigned PRF_IDX_W = 6;
  localparam int unsigned RS_TYPE_W = 2;

  typedef struct packed {
    logic [7:0]           opcode;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [RS_TYPE_W-1:0] rs_type;
    logic [PRF_IDX_W-1:0] rs1_phy;
    logic                 rs1_valid;
    logic [PRF_IDX_W-1:0] rs2_phy;
    logic                 rs2_valid;
  } uop_t;

endpackage

// File: rtl/ds_dispatch_if.sv
// ds_dispatch_if: bundle between the dispatch stage and its neighbours.
// Signals:
//   flush               synchronous pipeline flush
//   rn_valid/rn_uop     group offered by rename, rn_ready is the accept
//   ds_valid/ds_uop     per-RS, per-lane push plus the broadcast group
//   rs_ready            per-RS "at least ID_WIDTH free slots"
//   cdb_valid/cdb_rd_phy common data bus wakeup snoop
// Modports: slave is the dispatch stage, master is everything around it
// (rename, the reservation stations and the CDB).
interface ds_dispatch_if #(
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned NUM_RS    = 3,
  parameter int unsigned CDB_WIDTH = 3,
  parameter int unsigned PRF_IDX   = 6,
  parameter type         UOP_T     = ds_dispatch_pkg::uop_t
);

  logic                                 flush;
  logic [ID_WIDTH-1:0]                  rn_valid;
  UOP_T [ID_WIDTH-1:0]                  rn_uop;
  logic                                 rn_ready;
  logic [NUM_RS-1:0][ID_WIDTH-1:0]      ds_valid;
  UOP_T [ID_WIDTH-1:0]                  ds_uop;
  logic [NUM_RS-1:0]                    rs_ready;
  logic [CDB_WIDTH-1:0]                 cdb_valid;
  logic [CDB_WIDTH-1:0][PRF_IDX-1:0]    cdb_rd_phy;

  modport master (
    output flush, rn_valid, rn_uop, rs_ready, cdb_valid, cdb_rd_phy,
    input  rn_ready, ds_valid, ds_uop
  );

  modport slave (
    input  flush, rn_valid, rn_uop, rs_ready, cdb_valid, cdb_rd_phy,
    output rn_ready, ds_valid, ds_uop
  );

endinterface

// File: rtl/ds_dispatch.sv
// ds_dispatch: one-group skid between rename and the reservation stations.
// Holds a single rename group, pushes each lane to the RS named by its
// rs_type once that RS reports room, and snoops the CDB so operands woken
// while the group waits (or in the push cycle itself) arrive marked ready.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   ds_dispatch_if.slave (flush, rename handshake, RS push, CDB snoop)
module ds_dispatch #(
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned NUM_RS    = 3,
  parameter int unsigned CDB_WIDTH = 3,
  parameter int unsigned PRF_IDX   = 6,
  parameter type         UOP_T     = ds_dispatch_pkg::uop_t
) (
  input  logic            clk,
  input  logic            rst,
  ds_dispatch_if.slave    bus
);

  localparam int unsigned RS_TYPE_W = 2;

  UOP_T [ID_WIDTH-1:0]             buf_uop;
  logic [ID_WIDTH-1:0]             pend;

  logic [ID_WIDTH-1:0]             rs1_hit;
  logic [ID_WIDTH-1:0]             rs2_hit;
  logic [NUM_RS-1:0][ID_WIDTH-1:0] push;
  logic [ID_WIDTH-1:0]             dispatching;
  UOP_T [ID_WIDTH-1:0]             uop_out;
  logic                            ready;
  logic                            accept;

  // CDB tag match against every buffered source operand.
  always_comb begin : wakeup_match
    rs1_hit = '0;
    rs2_hit = '0;
    for (int w = 0; w < int'(ID_WIDTH); w++) begin
      for (int c = 0; c < int'(CDB_WIDTH); c++) begin
        if (bus.cdb_valid[c] && (bus.cdb_rd_phy[c] == PRF_IDX'(buf_uop[w].rs1_phy)))
          rs1_hit[w] = 1'b1;
        if (bus.cdb_valid[c] && (bus.cdb_rd_phy[c] == PRF_IDX'(buf_uop[w].rs2_phy)))
          rs2_hit[w] = 1'b1;
      end
    end
  end

  // Per-RS push. All pending lanes of one type share rs_ready[t], so they
  // go together or not at all; types outside 0..NUM_RS-1 never match.
  always_comb begin : push_select
    push = '0;
    for (int t = 0; t < int'(NUM_RS); t++) begin
      for (int w = 0; w < int'(ID_WIDTH); w++) begin
        if (!bus.flush && pend[w] && bus.rs_ready[t] &&
            (buf_uop[w].rs_type == RS_TYPE_W'(t)))
          push[t][w] = 1'b1;
      end
    end
  end

  // Lanes leaving the buffer this cycle, regardless of target RS.
  always_comb begin : lane_leaving
    dispatching = '0;
    for (int t = 0; t < int'(NUM_RS); t++)
      dispatching = dispatching | push[t];
  end

  // Outgoing group: buffered copy plus same-cycle wakeups.
  always_comb begin : uop_merge
    uop_out = buf_uop;
    for (int w = 0; w < int'(ID_WIDTH); w++) begin
      uop_out[w].rs1_valid = buf_uop[w].rs1_valid | rs1_hit[w];
      uop_out[w].rs2_valid = buf_uop[w].rs2_valid | rs2_hit[w];
    end
  end

  // Ready as soon as every still-pending lane leaves this cycle.
  assign ready  = !bus.flush && ((pend & ~dispatching) == '0);
  assign accept = ready && (|bus.rn_valid);

  assign bus.rn_ready = ready;
  assign bus.ds_valid = push;
  assign bus.ds_uop   = uop_out;

  // Pending mask: the only state that defines buffer occupancy.
  always_ff @(posedge clk or posedge rst) begin : pend_reg
    if (rst)
      pend <= '0;
    else if (bus.flush)
      pend <= '0;
    else if (accept)
      pend <= bus.rn_valid;
    else
      pend <= pend & ~dispatching;
  end

  // Payload is only meaningful under pend, so it carries no reset.
  // Incoming uops are loaded as-is; rename handles their same-cycle wakeup.
  always_ff @(posedge clk) begin : buf_reg
    if (accept) begin
      buf_uop <= bus.rn_uop;
    end else begin
      for (int w = 0; w < int'(ID_WIDTH); w++) begin
        if (pend[w] && rs1_hit[w])
          buf_uop[w].rs1_valid <= 1'b1;
        if (pend[w] && rs2_hit[w])
          buf_uop[w].rs2_valid <= 1'b1;
      end
    end
  end

  // A lane with an unmapped rs_type must stay parked until flush or reset.
  for (genvar w = 0; w < int'(ID_WIDTH); w++) begin : g_bad_type_chk
    a_bad_type_holds: assert property (
      @(posedge clk) disable iff (rst)
      (pend[w] && !bus.flush && (32'(buf_uop[w].rs_type) >= NUM_RS)) |=> pend[w]
    );
  end

endmodule

// File: tb/tb_ds_dispatch.sv
// tb_ds_dispatch: directed checks of ds_dispatch with hand-computed results.
// Inputs are driven 1 time unit after the rising edge; combinational outputs
// are sampled 1 time unit later, well before the next rising edge.
module tb_ds_dispatch;
  import ds_dispatch_pkg::*;

  localparam int unsigned ID_WIDTH  = 2;
  localparam int unsigned NUM_RS    = 3;
  localparam int unsigned CDB_WIDTH = 3;
  localparam int unsigned PRF_IDX   = 6;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  ds_dispatch_if #(
    .ID_WIDTH(ID_WIDTH), .NUM_RS(NUM_RS), .CDB_WIDTH(CDB_WIDTH),
    .PRF_IDX(PRF_IDX), .UOP_T(uop_t)
  ) bus ();

  ds_dispatch #(
    .ID_WIDTH(ID_WIDTH), .NUM_RS(NUM_RS), .CDB_WIDTH(CDB_WIDTH),
    .PRF_IDX(PRF_IDX), .UOP_T(uop_t)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic uop_t mk_uop(input logic [1:0] typ, input logic [7:0] opc,
                                  input logic [5:0] s1, input logic [5:0] s2);
    uop_t u;
    u = '0;
    u.rs_type = typ;
    u.opcode  = opc;
    u.rd_phy  = 6'd40;
    u.rs1_phy = s1;
    u.rs2_phy = s2;
    return u;
  endfunction

  // Advance to the drive point of the next cycle.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Let inputs settle, then sample.
  task automatic settle();
    #1;
  endtask

  initial begin : stim
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.rn_valid = '0;
    bus.rn_uop = '0;
    bus.rs_ready = '0;
    bus.cdb_valid = '0;
    bus.cdb_rd_phy = '0;

    // Reset state
    next_cyc(); settle();
    check("rst_rn_ready", 32'(bus.rn_ready), 32'd1);
    check("rst_ds_valid", 32'(bus.ds_valid), 32'd0);
    next_cyc();
    rst = 1'b0;

    // {int, mem}, all RS ready
    next_cyc();
    bus.rs_ready = 3'b111;
    bus.rn_valid = 2'b11;
    bus.rn_uop[0] = mk_uop(2'd0, 8'h10, 6'd1, 6'd2);
    bus.rn_uop[1] = mk_uop(2'd2, 8'h11, 6'd3, 6'd4);
    settle();
    check("t1_c0_rn_ready", 32'(bus.rn_ready), 32'd1);
    check("t1_c0_no_rn_to_ds", 32'(bus.ds_valid), 32'd0);
    next_cyc();
    bus.rn_valid = '0;
    settle();
    check("t1_c1_ds_int", 32'(bus.ds_valid[0]), 32'h1);
    check("t1_c1_ds_intm", 32'(bus.ds_valid[1]), 32'h0);
    check("t1_c1_ds_mem", 32'(bus.ds_valid[2]), 32'h2);
    check("t1_c1_rn_ready", 32'(bus.rn_ready), 32'd1);
    check("t1_c1_opc1", 32'(bus.ds_uop[1].opcode), 32'h11);
    next_cyc(); settle();
    check("t1_c2_idle", 32'(bus.ds_valid), 32'd0);

    // {intm, int} with intm stalled three cycles, then {int,int} back-to-back
    next_cyc();
    bus.rs_ready = 3'b101;
    bus.rn_valid = 2'b11;
    bus.rn_uop[0] = mk_uop(2'd1, 8'h20, 6'd5, 6'd6);
    bus.rn_uop[1] = mk_uop(2'd0, 8'h21, 6'd7, 6'd8);
    settle();
    check("t2_c0_rn_ready", 32'(bus.rn_ready), 32'd1);
    next_cyc();
    bus.rn_valid = '0;
    settle();
    check("t2_c1_ds_int", 32'(bus.ds_valid[0]), 32'h2);
    check("t2_c1_ds_intm", 32'(bus.ds_valid[1]), 32'h0);
    check("t2_c1_rn_ready", 32'(bus.rn_ready), 32'd0);
    next_cyc(); settle();
    check("t2_c2_ds", 32'(bus.ds_valid), 32'd0);
    check("t2_c2_rn_ready", 32'(bus.rn_ready), 32'd0);
    next_cyc();
    bus.rn_valid = 2'b11;
    bus.rn_uop[0] = mk_uop(2'd0, 8'h30, 6'd9, 6'd10);
    bus.rn_uop[1] = mk_uop(2'd0, 8'h31, 6'd11, 6'd12);
    settle();
    check("t2_c3_rn_ready", 32'(bus.rn_ready), 32'd0);
    next_cyc();
    bus.rs_ready = 3'b111;
    settle();
    check("t2_c4_ds_intm", 32'(bus.ds_valid[1]), 32'h1);
    check("t2_c4_ds_int", 32'(bus.ds_valid[0]), 32'h0);
    check("t2_c4_rn_ready", 32'(bus.rn_ready), 32'd1);
    check("t2_c4_opc0", 32'(bus.ds_uop[0].opcode), 32'h20);
    next_cyc();
    bus.rn_valid = '0;
    settle();
    check("t3_int_pair", 32'(bus.ds_valid[0]), 32'h3);
    check("t3_int_pair_other", 32'({bus.ds_valid[2], bus.ds_valid[1]}), 32'h0);
    check("t3_opc1", 32'(bus.ds_uop[1].opcode), 32'h31);
    next_cyc(); settle();
    check("t3_idle", 32'(bus.ds_valid), 32'd0);

    // Wakeup snoop: mem lane rs1=12 rs2=20 stalled, lane1 not valid
    next_cyc();
    bus.rs_ready = 3'b011;
    bus.rn_valid = 2'b01;
    bus.rn_uop[0] = mk_uop(2'd2, 8'h40, 6'd12, 6'd20);
    bus.rn_uop[1] = mk_uop(2'd2, 8'h41, 6'd13, 6'd14);
    settle();
    check("t4_c0_rn_ready", 32'(bus.rn_ready), 32'd1);
    next_cyc();
    bus.rn_valid = '0;
    settle();
    check("t4_c1_stalled", 32'(bus.ds_valid), 32'd0);
    check("t4_c1_rs1_before", 32'(bus.ds_uop[0].rs1_valid), 32'd0);
    bus.cdb_valid = 3'b010;
    bus.cdb_rd_phy[1] = 6'd12;
    bus.cdb_rd_phy[0] = 6'd20;
    settle();
    check("t4_c1_rs1_same_cycle", 32'(bus.ds_uop[0].rs1_valid), 32'd1);
    next_cyc();
    bus.cdb_valid = '0;
    settle();
    check("t4_c2_rs1_held", 32'(bus.ds_uop[0].rs1_valid), 32'd1);
    check("t4_c2_rs2_no_wake", 32'(bus.ds_uop[0].rs2_valid), 32'd0);
    check("t4_c2_stalled", 32'(bus.ds_valid), 32'd0);
    next_cyc();
    bus.rs_ready = 3'b111;
    bus.cdb_valid = 3'b100;
    bus.cdb_rd_phy[2] = 6'd20;
    settle();
    check("t4_c3_push_mem", 32'(bus.ds_valid), 32'(6'b01_00_00));
    check("t4_c3_rs1", 32'(bus.ds_uop[0].rs1_valid), 32'd1);
    check("t4_c3_rs2_push_cycle", 32'(bus.ds_uop[0].rs2_valid), 32'd1);
    next_cyc();
    bus.cdb_valid = '0;
    settle();
    check("t4_c4_idle", 32'(bus.ds_valid), 32'd0);

    // Flush with a lane pending, new group accepted right after
    next_cyc();
    bus.rs_ready = 3'b001;
    bus.rn_valid = 2'b11;
    bus.rn_uop[0] = mk_uop(2'd1, 8'h50, 6'd1, 6'd1);
    bus.rn_uop[1] = mk_uop(2'd0, 8'h51, 6'd1, 6'd1);
    next_cyc();
    bus.rn_valid = '0;
    settle();
    check("t5_c1_ds_int", 32'(bus.ds_valid[0]), 32'h2);
    next_cyc();
    bus.flush = 1'b1;
    bus.rs_ready = 3'b111;
    bus.rn_valid = 2'b11;
    bus.rn_uop[0] = mk_uop(2'd0, 8'h5a, 6'd1, 6'd1);
    bus.rn_uop[1] = mk_uop(2'd0, 8'h5b, 6'd1, 6'd1);
    settle();
    check("t5_flush_ds", 32'(bus.ds_valid), 32'd0);
    check("t5_flush_rn_ready", 32'(bus.rn_ready), 32'd0);
    next_cyc();
    bus.flush = 1'b0;
    bus.rn_uop[0] = mk_uop(2'd0, 8'h60, 6'd1, 6'd1);
    bus.rn_uop[1] = mk_uop(2'd0, 8'h61, 6'd1, 6'd1);
    settle();
    check("t5_post_flush_ds", 32'(bus.ds_valid), 32'd0);
    check("t5_post_flush_rn_ready", 32'(bus.rn_ready), 32'd1);
    next_cyc();
    bus.rn_valid = '0;
    settle();
    check("t5_new_group_ds", 32'(bus.ds_valid), 32'(6'b00_00_11));
    check("t5_new_group_opc0", 32'(bus.ds_uop[0].opcode), 32'h60);

    // Unmapped rs_type parks the lane until flushed
    next_cyc();
    bus.rn_valid = 2'b01;
    bus.rn_uop[0] = mk_uop(2'd3, 8'h70, 6'd1, 6'd1);
    next_cyc();
    bus.rn_valid = '0;
    settle();
    check("t6_bad_type_ds", 32'(bus.ds_valid), 32'd0);
    check("t6_bad_type_rn_ready", 32'(bus.rn_ready), 32'd0);
    next_cyc();
    bus.flush = 1'b1;
    next_cyc();
    bus.flush = 1'b0;
    settle();
    check("t6_after_flush_rn_ready", 32'(bus.rn_ready), 32'd1);

    // Reset mid-cycle with pend = 2'b10
    next_cyc();
    bus.rs_ready = 3'b001;
    bus.rn_valid = 2'b11;
    bus.rn_uop[0] = mk_uop(2'd0, 8'h80, 6'd1, 6'd1);
    bus.rn_uop[1] = mk_uop(2'd1, 8'h81, 6'd1, 6'd1);
    next_cyc();
    bus.rn_valid = '0;
    settle();
    check("t7_c1_ds_int", 32'(bus.ds_valid[0]), 32'h1);
    next_cyc();
    bus.rs_ready = 3'b111;
    settle();
    check("t7_c2_ds_intm", 32'(bus.ds_valid[1]), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_ds_now", 32'(bus.ds_valid), 32'd0);
    check("t7_rst_rn_ready_now", 32'(bus.rn_ready), 32'd1);
    next_cyc();
    rst = 1'b0;
    settle();
    check("t7_post_rst_rn_ready", 32'(bus.rn_ready), 32'd1);
    check("t7_post_rst_ds", 32'(bus.ds_valid), 32'd0);
    next_cyc(); settle();
    check("t7_no_late_push", 32'(bus.ds_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
